// File: rtl/shot_responder.sv
// shot_responder: answers shots against a locked ship map.
// A SETUP phase places ship cells one by one, place_done arms the board once
// exactly SHIP_CELLS cells are placed, and each accepted shot produces one
// answer that is held until acknowledged. The answer appears two edges after
// the shot is accepted. The map bits are plain flops so reset can clear them.
// Optional feature macro: SHOT_RESPONDER_REPEAT_EN
//   defined   : answer_repeat reports shots on already-shot cells, and such
//               shots never count as hits.
//   undefined : answer_repeat is tied to 0, and a repeated shot on a ship cell
//               still reports a hit but does not decrement hits_left.
module shot_responder #(
  parameter int GRID_W     = 10,
  parameter int GRID_H     = 10,
  parameter int SHIP_CELLS = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              place_valid,
  input  logic [7:0]                        place_pos,
  input  logic                              place_done,
  input  logic                              shot_valid,
  input  logic [7:0]                        shot_pos,
  output logic                              shot_ready,
  output logic                              answer_valid,
  output logic                              answer_hit,
  output logic                              answer_repeat,
  input  logic                              answer_ack,
  output logic [$clog2(SHIP_CELLS+1)-1:0]   placed_cnt,
  output logic [$clog2(SHIP_CELLS+1)-1:0]   hits_left,
  output logic                              armed,
  output logic                              defeated
);

  localparam int CNT_W = $clog2(SHIP_CELLS + 1);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [2:0] {
    SETUP   = 3'd0,
    ARMED   = 3'd1,
    LOOKUP  = 3'd2,
    RESPOND = 3'd3,
    DEFEAT  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       shot_pos_reg;
  logic [CELLS-1:0] ship_map_reg;
  logic [CELLS-1:0] shot_map_reg;
  logic [CNT_W-1:0] placed_cnt_reg;
  logic [CNT_W-1:0] hits_left_reg;
  logic             answer_valid_reg;
  logic             answer_hit_reg;
  logic             answer_repeat_reg;

  // Position decode: flat cell index is row * GRID_W + column
  logic             place_in_range, shot_in_range;
  logic [IDX_W-1:0] place_idx, shot_idx;

  assign place_in_range = (int'(place_pos[7:4]) < GRID_H) && (int'(place_pos[3:0]) < GRID_W);
  assign shot_in_range  = (int'(shot_pos_reg[7:4]) < GRID_H) && (int'(shot_pos_reg[3:0]) < GRID_W);
  assign place_idx = IDX_W'(int'(place_pos[7:4]) * GRID_W + int'(place_pos[3:0]));
  assign shot_idx  = IDX_W'(int'(shot_pos_reg[7:4]) * GRID_W + int'(shot_pos_reg[3:0]));

  // Control decisions for the current cycle
  logic place_accept, arm_now, lookup_now, dec_now;
  logic cell_ship, cell_shot, fresh_hit, hit_calc, repeat_calc;

  assign place_accept = (state_reg == SETUP) && place_valid && place_in_range &&
                        !ship_map_reg[place_idx] && (placed_cnt_reg < CNT_W'(SHIP_CELLS));
  // place_done looks at the count before any same-cycle placement lands
  assign arm_now    = (state_reg == SETUP) && place_done && (placed_cnt_reg == CNT_W'(SHIP_CELLS));
  assign lookup_now = (state_reg == LOOKUP);

  assign cell_ship = shot_in_range && ship_map_reg[shot_idx];
  assign cell_shot = shot_in_range && shot_map_reg[shot_idx];
  assign fresh_hit = cell_ship && !cell_shot;
  assign dec_now   = lookup_now && fresh_hit && (hits_left_reg != '0);

`ifdef SHOT_RESPONDER_REPEAT_EN
  assign hit_calc    = fresh_hit;
  assign repeat_calc = cell_shot;
`else
  assign hit_calc    = cell_ship;
  assign repeat_calc = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= SETUP;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SETUP:   if (arm_now) state_next = ARMED;
      ARMED:   if (shot_valid) state_next = LOOKUP;
      LOOKUP:  state_next = RESPOND;
      RESPOND: if (answer_valid_reg && answer_ack)
                 state_next = (hits_left_reg == '0) ? DEFEAT : ARMED;
      DEFEAT:  state_next = DEFEAT;
      default: state_next = SETUP;
    endcase
  end

  // Per-cell map flops: ship bits set by placement, shot bits set by lookups
  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    always_ff @(posedge clk) begin
      if (!rst) begin
        ship_map_reg[gi] <= 1'b0;
        shot_map_reg[gi] <= 1'b0;
      end else begin
        if (place_accept && (place_idx == IDX_W'(gi)))
          ship_map_reg[gi] <= 1'b1;
        if (lookup_now && shot_in_range && (shot_idx == IDX_W'(gi)))
          shot_map_reg[gi] <= 1'b1;
      end
    end
  end

  // Counters and the latched shot position
  always_ff @(posedge clk) begin
    if (!rst) begin
      placed_cnt_reg <= '0;
      hits_left_reg  <= '0;
      shot_pos_reg   <= '0;
    end else begin
      if (place_accept)
        placed_cnt_reg <= placed_cnt_reg + CNT_W'(1);
      if (arm_now)
        hits_left_reg <= CNT_W'(SHIP_CELLS);
      else if (dec_now)
        hits_left_reg <= hits_left_reg - CNT_W'(1);
      if ((state_reg == ARMED) && shot_valid)
        shot_pos_reg <= shot_pos;
    end
  end

  // Answer registers: result captured in LOOKUP, presented one cycle into RESPOND
  always_ff @(posedge clk) begin
    if (!rst) begin
      answer_valid_reg  <= 1'b0;
      answer_hit_reg    <= 1'b0;
      answer_repeat_reg <= 1'b0;
    end else begin
      if (lookup_now) begin
        answer_hit_reg    <= hit_calc;
        answer_repeat_reg <= repeat_calc;
      end
      if ((state_reg == RESPOND) && !answer_valid_reg)
        answer_valid_reg <= 1'b1;
      else if (answer_ack)
        answer_valid_reg <= 1'b0;
    end
  end

  assign shot_ready    = (state_reg == ARMED);
  assign answer_valid  = answer_valid_reg;
  assign answer_hit    = answer_valid_reg && answer_hit_reg;
  assign answer_repeat = answer_valid_reg && answer_repeat_reg;
  assign placed_cnt    = placed_cnt_reg;
  assign hits_left     = hits_left_reg;
  assign armed         = (state_reg == ARMED) || (state_reg == LOOKUP) || (state_reg == RESPOND);
  assign defeated      = (state_reg == DEFEAT);

endmodule

// File: tb/tb_shot_responder.sv
// Testbench for shot_responder: randomized placement and shots checked
// against a board-level model (ship/shot grids and counters).
// Honours SHOT_RESPONDER_REPEAT_EN when the same define is given to the build.
module tb_shot_responder;
  localparam int GRID_W     = 10;
  localparam int GRID_H     = 10;
  localparam int SHIP_CELLS = 20;
  localparam int CNT_W      = $clog2(SHIP_CELLS + 1);
`ifdef SHOT_RESPONDER_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             place_valid = 1'b0;
  logic [7:0]       place_pos = '0;
  logic             place_done = 1'b0;
  logic             shot_valid = 1'b0;
  logic [7:0]       shot_pos = '0;
  logic             shot_ready;
  logic             answer_valid;
  logic             answer_hit;
  logic             answer_repeat;
  logic             answer_ack = 1'b0;
  logic [CNT_W-1:0] placed_cnt;
  logic [CNT_W-1:0] hits_left;
  logic             armed;
  logic             defeated;

  shot_responder #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .SHIP_CELLS(SHIP_CELLS)
  ) dut (
    .clk(clk), .rst(rst),
    .place_valid(place_valid), .place_pos(place_pos), .place_done(place_done),
    .shot_valid(shot_valid), .shot_pos(shot_pos), .shot_ready(shot_ready),
    .answer_valid(answer_valid), .answer_hit(answer_hit), .answer_repeat(answer_repeat),
    .answer_ack(answer_ack),
    .placed_cnt(placed_cnt), .hits_left(hits_left),
    .armed(armed), .defeated(defeated)
  );

  always #5 clk = ~clk;

  // Board model
  bit ship_m [16][16];
  bit shot_m [16][16];
  int placed_m = 0;
  int hits_m   = 0;
  bit armed_m  = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        ship_m[r][c] = 1'b0;
        shot_m[r][c] = 1'b0;
      end
    placed_m = 0;
    hits_m   = 0;
    armed_m  = 1'b0;
  endtask

  // One placement cycle (valid and/or done), then compare counters
  task automatic place(input bit valid, input logic [7:0] pos, input bit done);
    int  r, c;
    bit  acc, arm;
    r   = int'(pos[7:4]);
    c   = int'(pos[3:0]);
    acc = valid && !armed_m && (r < GRID_H) && (c < GRID_W) && !ship_m[r][c] && (placed_m < SHIP_CELLS);
    arm = done && !armed_m && (placed_m == SHIP_CELLS);
    place_valid = valid;
    place_pos   = pos;
    place_done  = done;
    step();
    place_valid = 1'b0;
    place_done  = 1'b0;
    if (acc) begin
      ship_m[r][c] = 1'b1;
      placed_m++;
    end
    if (arm) begin
      armed_m = 1'b1;
      hits_m  = SHIP_CELLS;
    end
    check("placed_cnt", 32'(placed_cnt), placed_m);
    check("armed", 32'(armed), 32'(armed_m));
    $display("[TB] place valid=%0b pos=%02h done=%0b placed_cnt=%0d armed=%0b",
             valid, pos, done, placed_cnt, armed);
  endtask

  // Pick a random in-range cell not yet occupied in the model
  function automatic logic [7:0] free_cell();
    int r, c;
    r = 0; c = 0;
    for (int k = 0; k < 1000; k++) begin
      r = $urandom_range(0, GRID_H - 1);
      c = $urandom_range(0, GRID_W - 1);
      if (!ship_m[r][c]) break;
    end
    return 8'(r * 16 + c);
  endfunction

  // One complete shot transaction: accept, fixed latency, optional hold, ack
  task automatic fire(input logic [7:0] pos, input int hold, input bit early_ack);
    int r, c;
    bit in_rng, was, shp, exp_hit, exp_rep;
    r      = int'(pos[7:4]);
    c      = int'(pos[3:0]);
    in_rng = (r < GRID_H) && (c < GRID_W);
    was    = in_rng && shot_m[r][c];
    shp    = in_rng && ship_m[r][c];
    exp_hit = REPEAT_EN ? (shp && !was) : shp;
    exp_rep = REPEAT_EN ? was : 1'b0;
    if (shp && !was && hits_m > 0) hits_m--;
    if (in_rng) shot_m[r][c] = 1'b1;

    check("shot_ready_pre", 32'(shot_ready), 1);
    shot_valid = 1'b1;
    shot_pos   = pos;
    step();                                   // edge N: shot accepted
    if (hold == 0) shot_valid = 1'b0;
    if (early_ack) answer_ack = 1'b1;
    check("lookup_valid", 32'(answer_valid), 0);
    check("lookup_ready", 32'(shot_ready), 0);
    step();                                   // edge N+1
    check("n1_valid", 32'(answer_valid), 0);
    step();                                   // edge N+2
    check("answer_valid", 32'(answer_valid), 1);
    check("answer_hit", 32'(answer_hit), 32'(exp_hit));
    check("answer_repeat", 32'(answer_repeat), 32'(exp_rep));
    check("hits_left", 32'(hits_left), hits_m);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 32'(answer_valid), 1);
      check("hold_hit", 32'(answer_hit), 32'(exp_hit));
      check("hold_repeat", 32'(answer_repeat), 32'(exp_rep));
      check("hold_ready", 32'(shot_ready), 0);
      check("hold_hits_left", 32'(hits_left), hits_m);
    end
    answer_ack = 1'b1;
    shot_valid = 1'b0;
    step();
    answer_ack = 1'b0;
    check("post_ack_valid", 32'(answer_valid), 0);
    check("post_ack_hit", 32'(answer_hit), 0);
    check("defeated", 32'(defeated), 32'(hits_m == 0));
    check("shot_ready_post", 32'(shot_ready), 32'(hits_m != 0));
    $display("[TB] shot pos=%02h hit=%0b repeat=%0b hits_left=%0d defeated=%0b",
             pos, exp_hit, exp_rep, hits_left, defeated);
  endtask

  initial begin
    logic [7:0] pos;
    clear_model();

    // Reset state
    step();
    step();
    check("rst_placed_cnt", 32'(placed_cnt), 0);
    check("rst_hits_left", 32'(hits_left), 0);
    check("rst_armed", 32'(armed), 0);
    check("rst_defeated", 32'(defeated), 0);
    check("rst_shot_ready", 32'(shot_ready), 0);
    check("rst_answer_valid", 32'(answer_valid), 0);
    rst = 1'b1;

    // Duplicate and out-of-range placements, then an early place_done
    place(1'b1, 8'h33, 1'b0);
    place(1'b1, 8'h33, 1'b0);
    place(1'b1, 8'hA0, 1'b0);
    place(1'b0, 8'h00, 1'b1);

    // Random placements (mix of valid, duplicate, out of range) up to 19 cells
    for (int k = 0; k < 2000 && placed_m < SHIP_CELLS - 1; k++) begin
      if ($urandom_range(0, 3) == 0) pos = 8'($urandom_range(0, 255));
      else pos = 8'($urandom_range(0, GRID_H - 1) * 16 + $urandom_range(0, GRID_W - 1));
      place(1'b1, pos, 1'b0);
    end

    // Last placement together with place_done: done sees the old count
    place(1'b1, free_cell(), 1'b1);
    // Board full: a further placement is dropped
    place(1'b1, free_cell(), 1'b0);
    // Arm
    place(1'b0, 8'h00, 1'b1);
    check("armed_hits_left", 32'(hits_left), SHIP_CELLS);
    check("armed_shot_ready", 32'(shot_ready), 1);
    // Placement inputs ignored once armed
    place(1'b1, free_cell(), 1'b1);

    // First shot at 0x33, then the repeat with shot_valid held during RESPOND
    fire(8'h33, 0, 1'b0);
    fire(8'h33, 5, 1'b0);

    // Random shots, half with ack raised before the answer appears
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) pos = 8'($urandom_range(0, 255));
      else pos = 8'($urandom_range(0, GRID_H - 1) * 16 + $urandom_range(0, GRID_W - 1));
      fire(pos, 0, 1'(i % 2));
    end

    // Sink the remaining ship cells
    for (int r = 0; r < GRID_H; r++)
      for (int c = 0; c < GRID_W; c++)
        if (ship_m[r][c] && !shot_m[r][c])
          fire(8'(r * 16 + c), 0, 1'b0);

    check("final_defeated", 32'(defeated), 1);
    check("final_armed", 32'(armed), 0);
    check("final_hits_left", 32'(hits_left), 0);

    // Shots are refused in DEFEAT
    shot_valid = 1'b1;
    shot_pos   = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      check("defeat_ready", 32'(shot_ready), 0);
      check("defeat_valid", 32'(answer_valid), 0);
      check("defeat_hold", 32'(defeated), 1);
    end
    shot_valid = 1'b0;

    // One-cycle reset returns to SETUP
    rst = 1'b0;
    step();
    rst = 1'b1;
    clear_model();
    check("rst2_placed_cnt", 32'(placed_cnt), 0);
    check("rst2_hits_left", 32'(hits_left), 0);
    check("rst2_defeated", 32'(defeated), 0);
    check("rst2_armed", 32'(armed), 0);
    // SETUP accepts placements again
    place(1'b1, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shot_responder.md
SHOT_RESPONDER -- requirements
Module: shot_responder

Interface
REQ-001 The block SHALL have parameter GRID_W, default 10, meaning the number of board columns (max 16).
REQ-002 The block SHALL have parameter GRID_H, default 10, meaning the number of board rows (max 16).
REQ-003 The block SHALL have parameter SHIP_CELLS, default 20, meaning the number of occupied cells required to arm the board.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port place_valid, input, 1 bit: strobe marking the cell at place_pos as ship-occupied.
REQ-007 The block SHALL have port place_pos, input, 8 bits: [7:4] row, [3:0] column.
REQ-008 The block SHALL have port place_done, input, 1 bit: request to lock the map and arm the board.
REQ-009 The block SHALL have port shot_valid, input, 1 bit: an incoming shot is offered.
REQ-010 The block SHALL have port shot_pos, input, 8 bits: [7:4] row, [3:0] column.
REQ-011 The block SHALL have port shot_ready, output, 1 bit: the block accepts a shot this cycle.
REQ-012 The block SHALL have port answer_valid, output, 1 bit: the answer is present.
REQ-013 The block SHALL have port answer_hit, output, 1 bit: the shot struck an occupied, previously unstruck cell.
REQ-014 The block SHALL have port answer_repeat, output, 1 bit: the shot targeted an already-shot cell.
REQ-015 The block SHALL have port answer_ack, input, 1 bit: the consumer has taken the answer.
REQ-016 The block SHALL have port placed_cnt, output, $clog2(SHIP_CELLS+1) bits: the number of occupied cells placed.
REQ-017 The block SHALL have port hits_left, output, $clog2(SHIP_CELLS+1) bits: the number of occupied cells not yet hit.
REQ-018 The block SHALL have port armed, output, 1 bit: the map is locked (state ARMED, LOOKUP or RESPOND).
REQ-019 The block SHALL have port defeated, output, 1 bit: all ship cells have been hit.

Function
REQ-020 The block SHALL hold a GRID_W*GRID_H ship map and shot map, and SHALL implement FSM states SETUP, ARMED, LOOKUP, RESPOND, DEFEAT.
REQ-021 A position SHALL be in range when row < GRID_H and column < GRID_W.
REQ-022 In SETUP, a place_valid with an in-range, unoccupied position and placed_cnt < SHIP_CELLS SHALL set the ship bit and increment placed_cnt next cycle; in every other case it SHALL be ignored.
REQ-023 In SETUP, place_done SHALL move the FSM to ARMED and load hits_left = SHIP_CELLS only when placed_cnt == SHIP_CELLS; otherwise it SHALL be ignored.
REQ-024 If place_valid and place_done are both high in the same cycle, the placement SHALL be evaluated first, and place_done SHALL use the pre-update placed_cnt.
REQ-025 shot_ready SHALL be 1 only in ARMED; shot_valid & shot_ready SHALL latch shot_pos and move the FSM to LOOKUP.
REQ-026 LOOKUP SHALL last exactly 1 cycle.
REQ-027 In LOOKUP, the repeat condition SHALL be the shot bit set.
REQ-028 In LOOKUP, hit SHALL equal ship bit AND NOT shot bit.
REQ-029 In LOOKUP, an out-of-range shot SHALL give hit=0, repeat=0 and modify no map.
REQ-030 In LOOKUP, an in-range shot SHALL set its shot bit.
REQ-031 In LOOKUP, a hit SHALL decrement hits_left; hits_left SHALL never wrap below 0.
REQ-032 The FSM SHALL move from LOOKUP to RESPOND.
REQ-033 In RESPOND, answer_valid, answer_hit and answer_repeat SHALL be held stable until answer_ack.
REQ-034 answer_ack in the same cycle answer_valid first rises SHALL be honoured.
REQ-035 On answer_ack in RESPOND, the FSM SHALL move to DEFEAT if hits_left == 0, else to ARMED.
REQ-036 Latency SHALL be fixed: a shot accepted at edge N SHALL produce answer_valid=1 after edge N+2.
REQ-037 In DEFEAT, defeated SHALL be 1 and shot_ready SHALL be 0, with the FSM remaining there until reset.
REQ-038 answer_valid, answer_hit and answer_repeat SHALL be 0 outside RESPOND.
REQ-039 place_* inputs SHALL be ignored outside SETUP; answer_ack SHALL be ignored outside RESPOND.

Reset
REQ-040 rst=0 on a rising edge SHALL set the FSM to SETUP, clear both maps, and zero placed_cnt, hits_left, shot_ready, answer_valid, answer_hit, answer_repeat, armed and defeated.
REQ-041 A reset asserted in any state, including mid-LOOKUP or RESPOND, SHALL abort the operation without emitting an answer.

Configuration
REQ-042 With macro SHOT_RESPONDER_REPEAT_EN defined, answer_repeat SHALL behave as specified in REQ-027.
REQ-043 Without SHOT_RESPONDER_REPEAT_EN, answer_repeat SHALL be tied to 0.
REQ-044 Without SHOT_RESPONDER_REPEAT_EN, a repeated shot on an occupied cell SHALL report answer_hit=1 without decrementing hits_left; the shot map SHALL still be kept.

Verification
REQ-045 The bench SHALL place 20 distinct cells and then pulse place_done, and SHALL check placed_cnt=20, armed=1, hits_left=20 and shot_ready=1.
REQ-046 The bench SHALL place cell 0x33 twice plus out-of-range cell 0xA0, and SHALL check placed_cnt=1; place_done SHALL then leave armed=0.
REQ-047 The bench SHALL fire a shot at occupied 0x33 accepted at edge N, and SHALL check answer_valid=1 after N+2 with answer_hit=1 and hits_left=19.
REQ-048 The bench SHALL then fire at 0x33 again, and SHALL check answer_hit=0 and answer_repeat=1 (REPEAT_EN defined), or answer_hit=1 and answer_repeat=0 (undefined), with hits_left=19 in both cases.
REQ-049 The bench SHALL hold answer_ack=0 for 5 cycles while shot_valid stays high, and SHALL check that the answer is stable, shot_ready=0 and no second shot is taken.
REQ-050 The bench SHALL hit all 20 cells and then ack, and SHALL check defeated=1 and shot_ready=0; it SHALL then drive rst=0 for one cycle and check state SETUP with placed_cnt=0.
